// File: rtl/regfile_writeback.sv
// Register file write-side initiator: fixed-priority load path plus an in-order ALU
// result FIFO, one registered write per cycle, and a pending-write hazard bitmap.
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [4:0]                        alu_rd,
  input  logic [XLEN-1:0]                   alu_value,
  input  logic                              mem_valid,
  output logic                              mem_ready,
  input  logic [4:0]                        mem_rd,
  input  logic [XLEN-1:0]                   mem_value,
  output logic                              input_enable,
  output logic [4:0]                        input_select,
  output logic [XLEN-1:0]                   input_value,
  output logic [31:0]                       pending,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  function automatic logic [31:0] onehot(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

  logic [4:0]      fifo_rd_r  [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_val_r [FIFO_DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic            input_enable_r;
  logic [4:0]      input_select_r;
  logic [XLEN-1:0] input_value_r;

  logic            enq_s;
  logic            deq_s;
  logic            grant_s;
  logic [4:0]      grant_rd_s;
  logic [XLEN-1:0] grant_val_s;
  logic [31:0]     pending_s;

  // Ready depends only on registered occupancy, so a same-cycle dequeue never frees a slot.
  assign alu_ready = rst_n & (count_r != CNT_FULL);
  assign mem_ready = rst_n;
  assign enq_s     = alu_valid & alu_ready;

  // Grant selection: load result first, then the FIFO head.
  always_comb begin
    grant_s     = 1'b0;
    grant_rd_s  = 5'd0;
    grant_val_s = {XLEN{1'b0}};
    deq_s       = 1'b0;
    if (mem_valid) begin
      grant_s     = 1'b1;
      grant_rd_s  = mem_rd;
      grant_val_s = mem_value;
    end else if (count_r != CNT_ZERO) begin
      grant_s     = 1'b1;
      grant_rd_s  = fifo_rd_r[head_r];
      grant_val_s = fifo_val_r[head_r];
      deq_s       = 1'b1;
    end else begin
      grant_s     = 1'b0;
    end
  end

  // Hazard bitmap over live FIFO entries and the write currently on the port.
  always_comb begin
    pending_s = input_enable_r ? onehot(input_select_r) : 32'd0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      pending_s = pending_s |
                  ((CW'(k) < count_r) ? onehot(fifo_rd_r[head_r + PW'(k)]) : 32'd0);
    end
    pending_s[0] = 1'b0;
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && enq_s) begin
      fifo_rd_r[tail_r]  <= alu_rd;
      fifo_val_r[tail_r] <= alu_value;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r         <= {PW{1'b0}};
      tail_r         <= {PW{1'b0}};
      count_r        <= CNT_ZERO;
      input_enable_r <= 1'b0;
      input_select_r <= 5'd0;
      input_value_r  <= {XLEN{1'b0}};
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1);
      end
      if (enq_s && !deq_s) begin
        count_r <= count_r + CW'(1);
      end else if (!enq_s && deq_s) begin
        count_r <= count_r - CW'(1);
      end
      if (grant_s) begin
        input_enable_r <= (grant_rd_s != 5'd0);
        input_select_r <= grant_rd_s;
        input_value_r  <= grant_val_s;
      end else begin
        input_enable_r <= 1'b0;
      end
    end
  end

  assign input_enable = input_enable_r;
  assign input_select = input_select_r;
  assign input_value  = input_value_r;
  assign pending      = pending_s;
  assign fifo_count   = count_r;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback using immediate assertions.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_value;
  logic        input_enable;
  logic [4:0]  input_select;
  logic [31:0] input_value;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  regfile_writeback #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_value(mem_value),
    .input_enable(input_enable), .input_select(input_select), .input_value(input_value),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
    alu_rd = 5'd7; alu_value = 32'h1111_1111; mem_rd = 5'd8; mem_value = 32'h2222_2222;
    #1;
    tick(); tick();
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_enable", input_enable, 0);
    chk("rst_select", input_select, 0);
    chk("rst_value", input_value, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("rel_alu_ready", alu_ready, 1);
    chk("rel_mem_ready", mem_ready, 1);
    tick();
    chk("idle_enable", input_enable, 0);

    // Load write to x5
    mem_valid = 1'b1; mem_rd = 5'd5; mem_value = 32'h3f3f_3f3f;
    tick();
    mem_valid = 1'b0;
    chk("mem_enable", input_enable, 1);
    chk("mem_select", input_select, 5);
    chk("mem_value", input_value, 32'h3f3f_3f3f);
    chk("mem_pending", pending, 32'h0000_0020);
    tick();
    chk("mem_enable_off", input_enable, 0);
    chk("mem_pending_off", pending, 0);
    chk("mem_select_hold", input_select, 5);

    // ALU write to x1
    alu_valid = 1'b1; alu_rd = 5'd1; alu_value = 32'hfcfc_fcfc;
    tick();
    alu_valid = 1'b0;
    chk("alu_count1", fifo_count, 1);
    chk("alu_pending_q", pending, 32'h0000_0002);
    chk("alu_enable_n1", input_enable, 0);
    tick();
    chk("alu_enable", input_enable, 1);
    chk("alu_select", input_select, 1);
    chk("alu_value", input_value, 32'hfcfc_fcfc);
    chk("alu_count0", fifo_count, 0);
    chk("alu_pending_p", pending, 32'h0000_0002);
    tick();
    chk("alu_enable_off", input_enable, 0);
    chk("alu_pending_off", pending, 0);

    // x0 writes from both sources
    mem_valid = 1'b1; mem_rd = 5'd0; mem_value = 32'h3f3f_3f3f;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'h0000_0001;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("x0_mem_enable", input_enable, 0);
    chk("x0_pending_a", pending, 0);
    chk("x0_count1", fifo_count, 1);
    tick();
    chk("x0_alu_enable", input_enable, 0);
    chk("x0_pending_b", pending, 0);
    chk("x0_count0", fifo_count, 0);
    chk("x0_alu_value", input_value, 32'h0000_0001);
    chk("x0_alu_select", input_select, 0);

    // Fill the FIFO while loads hold priority
    mem_valid = 1'b1; mem_rd = 5'd2; mem_value = 32'h0000_0022;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_value = 32'(32'hA + i);
      #1;
      chk("fill_ready", alu_ready, 1);
      tick();
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", alu_ready, 0);
    chk("full_pending", pending, 32'h0000_3C04);
    chk("full_mem_select", input_select, 2);
    alu_rd = 5'd14; alu_value = 32'h0000_000E;
    tick();
    chk("refuse_count", fifo_count, 4);
    chk("refuse_pending", pending, 32'h0000_3C04);
    // Dequeue starts; the same-cycle push must still be refused
    mem_valid = 1'b0;
    tick();
    alu_valid = 1'b0;
    chk("drain0_enable", input_enable, 1);
    chk("drain0_select", input_select, 10);
    chk("drain0_value", input_value, 32'h0000_000A);
    chk("drain0_count", fifo_count, 3);
    chk("drain0_ready", alu_ready, 1);
    chk("drain0_pending", pending, 32'h0000_3C00);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_enable", input_enable, 1);
      chk("drain_select", input_select, 64'(10 + i));
      chk("drain_value", input_value, 64'(32'hA + i));
      chk("drain_count", fifo_count, 64'(3 - i));
    end
    tick();
    chk("drain_done_enable", input_enable, 0);
    chk("drain_done_pending", pending, 0);

    // Reset with three queued ALU results
    mem_valid = 1'b1; mem_rd = 5'd3; mem_value = 32'h0000_0033;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_value = 32'(32'h100 + i);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("mid_count3", fifo_count, 3);
    chk("mid_pending3", pending, 32'h0070_0008);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_enable", input_enable, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_enable", input_enable, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side initiator for the 32x32 register file.
- Collects results from the load/store unit and the ALU, arbitrates between them, and buffers ALU results in a small in-order FIFO.
- Drives the register file write port (input_enable/input_select/input_value) one transaction per cycle.
- Exports a pending-write bitmap that issue logic uses for hazard checks.

Parameters:
- XLEN, 32, data width; matches register file width.
- FIFO_DEPTH, 4, ALU result FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  5  ALU destination register.
- alu_value  in  XLEN  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high.
- mem_rd  in  5  load destination register.
- mem_value  in  XLEN  load result.
- input_enable  out  1  register file write enable (registered).
- input_select  out  5  register file write address (registered).
- input_value  out  XLEN  register file write data (registered).
- pending  out  32  bit i high = a write to xi is queued or presented on the port.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current ALU FIFO occupancy.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Next cycle: input_enable=0, input_select=0, input_value=0; FIFO emptied; fifo_count=0; pending=0.
  - While rst_n is low, alu_ready=0 and mem_ready=0; all inputs are ignored.
  - Reset mid-operation discards every queued entry; none is written afterwards.
- Handshakes:
  - mem_ready=1 whenever rst_n=1. The load path has fixed priority and no buffer.
  - alu_ready = rst_n & (fifo_count != FIFO_DEPTH).
  - alu_ready is computed from the registered count only. A same-cycle dequeue does not open a slot; a full FIFO refuses the enqueue for that cycle.
- Enqueue: alu_valid & alu_ready at edge -> entry {rd,value} written at the tail; the count increments.
- Grant, per cycle:
  - If mem_valid: grant mem.
  - Else if FIFO non-empty: grant the FIFO head and dequeue at the edge.
  - Else: no grant.
  - Enqueue and dequeue in the same cycle leave the count unchanged; pointers wrap modulo FIFO_DEPTH.
- Output stage, updated every edge:
  - input_enable <= granted & (rd != 0).
  - input_select <= granted rd.
  - input_value <= granted value.
  - With no grant: input_enable <= 0; select and value hold their previous values.
- x0 writes: accepted and dequeued normally; never assert input_enable; never set pending[0].
- Latency:
  - Mem accepted in cycle N -> input_enable high in cycle N+1; the register file captures at the end of N+1.
  - ALU accepted in cycle N with no competing mem -> dequeued in N+1 -> input_enable high in N+2.
- Ordering:
  - FIFO is strictly in-order.
  - A mem result may overtake queued ALU results. Issue logic avoids WAW by checking pending before issuing.
  - No starvation guard: continuous mem_valid stalls the FIFO indefinitely.
- pending: combinational OR over all valid FIFO entries' rd (one-hot) and (input_enable ? onehot(input_select) : 0). Bit 0 is forced to 0.
- Widths: no arithmetic on data; values pass through unmodified. fifo_count never exceeds FIFO_DEPTH.

Test Plan:
- Reset: rst_n low for 2 cycles with alu_valid=mem_valid=1 -> alu_ready=mem_ready=0, input_enable=0, pending=0, fifo_count=0. First cycle after release -> alu_ready=1, mem_ready=1.
- Mem write: mem rd=5, value 0x3f3f3f3f accepted in cycle N -> cycle N+1: input_enable=1, input_select=5, input_value=0x3f3f3f3f, pending[5]=1. Cycle N+2: input_enable=0, pending=0.
- ALU write: rd=1, value 0xfcfcfcfc in cycle N, mem idle -> fifo_count=1 and pending[1]=1 in N+1. Write presented in N+2. fifo_count=0 in N+2.
- x0 drop: mem rd=0, value 0x3f3f3f3f, and ALU rd=0, value 0x1 -> input_enable never high, pending stays 0, fifo_count returns to 0.
- Full/priority: hold mem_valid (rd=2) while pushing ALU rd=10,11,12,13 (values 0xA..0xD):
  - alu_ready=0 after the 4th push; fifo_count=4; pending bits 2,10..13 set.
  - A 5th push is refused.
  - Drop mem_valid -> four consecutive writes to x10..x13 in order with values 0xA..0xD.
  - alu_ready=1 the cycle after the first dequeue.
- Reset mid-operation: fifo_count=3 with mem idle, rst_n low for one cycle -> next cycle fifo_count=0, pending=0, input_enable=0. No write to any queued rd in the following 5 cycles.
